tpu_ctrl: RTL
=============

Name: tpu_ctrl

Overview:
Byte-serial host controller that sequences the tpu systolic array from the 8-bit chip pins. It accepts opcode/data bytes, fills the weight and input buffers, then pulses start and waits for done. It streams accumulator results back as bytes. It sits between the tt_um_tpu pin wrapper and the tpu core.

Parameters:
N, 2, array dimension; each buffer holds N*N entries.
DATA_W, 8, weight/input element width; equals host byte width.
ACC_W, 16, result width; must be a multiple of 8, sent as ACC_W/8 bytes, MSB first.
TIMEOUT, 255, RUN watchdog limit in cycles (used only with the optional feature).

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
host_data  in  8  command/data byte
host_valid  in  1  host_data valid
host_ready  out  1  controller accepts host_data this cycle
out_data  out  8  result byte
out_valid  out  1  out_data valid
out_ready  in  1  host consumes out_data
wbuf_we  out  1  weight buffer write strobe
ibuf_we  out  1  input buffer write strobe
buf_addr  out  $clog2(N*N)  write address, shared by both buffers
buf_wdata  out  DATA_W  write data
array_start  out  1  one-cycle start pulse to the array
array_done  in  1  array finished; level or pulse
rbuf_addr  out  $clog2(N*N)  result buffer read address
rbuf_rdata  in  ACC_W  result data, valid one cycle after rbuf_addr
busy  out  1  FSM not in IDLE
err  out  1  sticky error flag

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: all outputs 0; FSM in IDLE; idx=0; err=0.
- Handshakes: a byte is accepted on host_valid & host_ready. A result byte transfers on out_valid & out_ready. out_data is held stable while out_valid=1 and out_ready=0.
- Opcodes (accepted in IDLE only):
  - 0x01 LOAD_W -> LOAD_W
  - 0x02 LOAD_I -> LOAD_I
  - 0x03 RUN -> RUN_START
  - 0x04 READ -> RD_REQ
  - 0x05 CLR_ERR -> clears err, stays in IDLE
  - 0x00 NOP -> no effect
  - any other value -> sets err, stays in IDLE
- host_ready: 1 in IDLE, LOAD_W and LOAD_I; 0 in all other states.
- LOAD_W / LOAD_I:
  - Each accepted byte drives wbuf_we (or ibuf_we) for one cycle, with buf_addr=idx and buf_wdata=byte. Strobe, address and data are combinational from the accept.
  - idx then increments.
  - After the byte at idx=N*N-1: idx clears to 0 and the FSM returns to IDLE.
- RUN_START: array_start=1 for exactly one cycle, then RUN_WAIT.
- RUN_WAIT: array_done is sampled only in this state. array_done=1 -> IDLE next cycle.
- READ sequence:
  - RD_REQ: rbuf_addr=idx.
  - RD_CAP: capture rbuf_rdata into the shift register; byte counter=0.
  - RD_OUT: out_valid=1, out_data = top byte of the shift register.
  - On each transfer, shift left 8 bits. After ACC_W/8 bytes, idx increments and the FSM goes to RD_REQ.
  - When idx was N*N-1 at that point: idx clears to 0 and the FSM goes to IDLE.
- Result latency: the first result byte is valid 3 cycles after the READ opcode is accepted.
- busy = (state != IDLE).
- Boundary conditions:
  - idx wraps only at N*N-1.
  - Host bytes offered while host_ready=0 are ignored.
  - Reset in any state aborts the operation immediately and restores reset values. Partial buffer contents are not rewritten.
  - array_done asserted outside RUN_WAIT is ignored.

Optional Feature:
- Macro: TPU_CTRL_TIMEOUT_EN.
- Defined: a cycle counter runs in RUN_WAIT. If it reaches TIMEOUT without array_done, the FSM sets err and returns to IDLE. The counter clears on entering RUN_WAIT.
- Undefined: RUN_WAIT waits indefinitely, and TIMEOUT is unused.

Decomposition:
- Package tpu_pkg holds:
  - opcode enum (NOP, LOAD_W, LOAD_I, RUN, READ, CLR_ERR)
  - FSM state enum (IDLE, LOAD_W, LOAD_I, RUN_START, RUN_WAIT, RD_REQ, RD_CAP, RD_OUT)
  - default N/DATA_W/ACC_W constants
- One sub-module: tpu_byte_serializer (ACC_W load, byte shift-out with valid/ready, last-byte flag).

Test Plan:
- Reset, then LOAD_W followed by 0x11,0x22,0x33,0x44 -> wbuf_we pulses at addr 0..3 with matching data. FSM is back in IDLE, busy=0.
- RUN with array_done raised 5 cycles after array_start -> exactly one start pulse; busy falls the cycle after done.
- READ with rbuf holding {0x1234,0xABCD,0x0001,0xFFFF} and out_ready toggling 1/0 -> byte sequence 12 34 AB CD 00 01 FF FF. Data is stable while stalled.
- Opcode 0x7E -> err=1, no strobes, host_ready stays 1. Then 0x05 -> err=0.
- Reset asserted mid-LOAD_I after 2 bytes, then LOAD_I plus 4 bytes -> writes restart at addr 0.
- With TPU_CTRL_TIMEOUT_EN and TIMEOUT=20: RUN with no array_done -> err=1 and IDLE after 20 RUN_WAIT cycles. A later array_done is ignored.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared opcodes, FSM states and default sizes for the tpu host controller.
package tpu_pkg;

  localparam int N_DEF       = 2;
  localparam int DATA_W_DEF  = 8;
  localparam int ACC_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [7:0] {
    OP_NOP     = 8'h00,
    OP_LOAD_W  = 8'h01,
    OP_LOAD_I  = 8'h02,
    OP_RUN     = 8'h03,
    OP_READ    = 8'h04,
    OP_CLR_ERR = 8'h05
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_I,
    S_RUN_START,
    S_RUN_WAIT,
    S_RD_REQ,
    S_RD_CAP,
    S_RD_OUT
  } state_e;

endpackage

// File: rtl/tpu_byte_serializer.sv
// Loads one ACC_W result and shifts it out MSB byte first on each transfer.
module tpu_byte_serializer #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [ACC_W-1:0] i_data,
  input  logic             i_shift,
  output logic [7:0]       o_byte,
  output logic             o_last
);

  localparam int NB = ACC_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [ACC_W-1:0] r_sh;
  logic [CW-1:0]    r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= i_data;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sh  <= r_sh << 8;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_byte = r_sh[ACC_W-1 -: 8];
  assign o_last = (r_cnt == CW'(NB - 1));

endmodule

// File: rtl/tpu_ctrl.sv
// Byte-serial host sequencer for the tpu array.
// Optional RUN watchdog: define TPU_CTRL_TIMEOUT_EN.
module tpu_ctrl
  import tpu_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                host_data,
  input  logic                      host_valid,
  output logic                      host_ready,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      wbuf_we,
  output logic                      ibuf_we,
  output logic [$clog2(N*N)-1:0]    buf_addr,
  output logic [DATA_W-1:0]         buf_wdata,
  output logic                      array_start,
  input  logic                      array_done,
  output logic [$clog2(N*N)-1:0]    rbuf_addr,
  input  logic [ACC_W-1:0]          rbuf_rdata,
  output logic                      busy,
  output logic                      err
);

  localparam int AW = $clog2(N*N);

  state_e        r_state, w_nxt;
  logic [AW-1:0] r_idx;
  logic          r_err;
  logic          w_acc, w_idx_inc, w_idx_clr;
  logic          w_err_set, w_err_clr, w_load;
  logic          w_last_idx, w_last_byte;
  logic [7:0]    w_byte;

  assign w_last_idx = (r_idx == AW'(N*N - 1));

`ifdef TPU_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_tmo <= '0;
    else if (r_state == S_RUN_START)
      r_tmo <= '0;
    else if (r_state == S_RUN_WAIT)
      r_tmo <= r_tmo + TW'(1);
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = |TIMEOUT;
`endif

  // host_ready is held low while reset is asserted so every output reads 0
  assign host_ready = ~reset & ((r_state == S_IDLE) ||
                                (r_state == S_LOAD_W) ||
                                (r_state == S_LOAD_I));
  assign w_acc = host_valid & host_ready;

  always_comb begin
    w_nxt       = r_state;
    wbuf_we     = 1'b0;
    ibuf_we     = 1'b0;
    array_start = 1'b0;
    out_valid   = 1'b0;
    w_load      = 1'b0;
    w_idx_inc   = 1'b0;
    w_idx_clr   = 1'b0;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          case (host_data)
            OP_NOP:     ;
            OP_LOAD_W:  w_nxt = S_LOAD_W;
            OP_LOAD_I:  w_nxt = S_LOAD_I;
            OP_RUN:     w_nxt = S_RUN_START;
            OP_READ:    w_nxt = S_RD_REQ;
            OP_CLR_ERR: w_err_clr = 1'b1;
            default:    w_err_set = 1'b1;
          endcase
        end
      end
      S_LOAD_W, S_LOAD_I: begin
        if (w_acc) begin
          wbuf_we = (r_state == S_LOAD_W);
          ibuf_we = (r_state == S_LOAD_I);
          if (w_last_idx) begin
            w_idx_clr = 1'b1;
            w_nxt     = S_IDLE;
          end else begin
            w_idx_inc = 1'b1;
          end
        end
      end
      S_RUN_START: begin
        array_start = 1'b1;
        w_nxt       = S_RUN_WAIT;
      end
      S_RUN_WAIT: begin
        if (array_done) begin
          w_nxt = S_IDLE;
`ifdef TPU_CTRL_TIMEOUT_EN
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          w_err_set = 1'b1;
          w_nxt     = S_IDLE;
`endif
        end
      end
      S_RD_REQ: w_nxt = S_RD_CAP;
      S_RD_CAP: begin
        w_load = 1'b1;
        w_nxt  = S_RD_OUT;
      end
      S_RD_OUT: begin
        out_valid = 1'b1;
        if (out_ready && w_last_byte) begin
          if (w_last_idx) begin
            w_idx_clr = 1'b1;
            w_nxt     = S_IDLE;
          end else begin
            w_idx_inc = 1'b1;
            w_nxt     = S_RD_REQ;
          end
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_idx_clr)
        r_idx <= '0;
      else if (w_idx_inc)
        r_idx <= r_idx + AW'(1);
      if (w_err_set)
        r_err <= 1'b1;
      else if (w_err_clr)
        r_err <= 1'b0;
    end
  end

  tpu_byte_serializer #(.ACC_W(ACC_W)) u_ser (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_data  (rbuf_rdata),
    .i_shift (out_valid & out_ready),
    .o_byte  (w_byte),
    .o_last  (w_last_byte)
  );

  assign buf_addr  = r_idx;
  assign rbuf_addr = r_idx;
  assign buf_wdata = (wbuf_we | ibuf_we) ? host_data : '0;
  assign out_data  = out_valid ? w_byte : 8'h00;
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;

endmodule
